// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: XLEN-cycle shift-add multiply and restoring divide.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow complete one edge after acceptance.
module muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            dbz
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            dbz_q, dbz_d;

  logic            a_sgn, b_sgn, b_zero;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   msum, trial, diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem, fin;
`ifdef MULDIV_EARLY_OUT_EN
  logic            ovf;
`endif

  always_comb begin
    a_sgn  = a[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                          (funct3 == 3'b100) | (funct3 == 3'b110));
    b_sgn  = b[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110));
    a_mag  = a_sgn ? -a : a;
    b_mag  = b_sgn ? -b : b;
    b_zero = (b == '0);
`ifdef MULDIV_EARLY_OUT_EN
    ovf    = ~funct3[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
`endif
  end

  // hi:lo holds partial product (mul) or remainder:quotient (div); m holds multiplicand/divisor
  always_comb begin
    msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    trial = {hi_q, lo_q[XLEN-1]};
    diff  = trial - {1'b0, m_q};

    prod = {hi_q, lo_q};
    if (sa_q ^ sb_q) prod = -prod;
    quo = (sa_q ^ sb_q) ? -lo_q : lo_q;
    if (bz_q) quo = '1;
    rem = sa_q ? -hi_q : hi_q;

    case (op_q)
      3'b000:                 fin = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin = quo;
      default:                fin = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bz_d     = bz_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CALC;
          op_d    = funct3;
          sa_d    = a_sgn;
          sb_d    = b_sgn;
          bz_d    = funct3[2] & b_zero;
          cnt_d   = CW'(XLEN);
          hi_d    = '0;
          lo_d    = funct3[2] ? a_mag : b_mag;
          m_d     = funct3[2] ? b_mag : a_mag;
`ifdef MULDIV_EARLY_OUT_EN
          // Preload so the normal finalize path yields a (rem) / all-ones or a (quotient) at once
          if (funct3[2] && (b_zero || ovf)) begin
            cnt_d = '0;
            hi_d  = b_zero ? a_mag : '0;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (op_q[2]) begin
            hi_d = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ~diff[XLEN]};
          end else begin
            hi_d = msum[XLEN:1];
            lo_d = {msum[0], lo_q[XLEN-1:1]};
          end
        end else begin
          result_d = fin;
          dbz_d    = bz_q;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bz_q     <= bz_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign dbz    = dbz_q;

endmodule
